ram_arbiter: RTL

Two-port arbiter and access sequencer in front of the single-ported RAM. It takes word read/write requests from an instruction-fetch requester (port 0) and a load/store requester (port 1), grants them round-robin and drives the RAM strobes, address and tri-state data bus. It guarantees that `ram_read` and `ram_write` are never high together. A write strobe only rises once address and data are stable, as the RAM's level-sensitive write requires.

---
 rtl/ram_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-port round-robin arbiter and access sequencer in front of a
// single-ported RAM with a level-sensitive write strobe and a shared
// tri-state data bus.
//
// Requester handshake (both ports): a requester raises req with we/addr/wdata
// and holds all of them stable until the one-cycle ack pulse. A req that is
// still high in the cycle after ack is treated as a brand-new request.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   p0_req/we/addr/wdata        port 0 (instruction fetch) request fields
//   p0_ack, p0_rdata            port 0 completion pulse and held read data
//   p1_*                        same for port 1 (load/store)
//   ram_read, ram_write         RAM strobes, never high together
//   ram_addr                    RAM word address (holds its value while idle)
//   ram_data                    RAM data bus, driven only in write states
//   busy                        high whenever an access is in progress
module ram_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WSETUP  = 3'd2,
        WSTROBE = 3'd3,
        WHOLD   = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;

    // last_grant doubles as "port currently being served" while busy,
    // because it is updated on every grant.
    logic          last_grant;
    logic [DW-1:0] wdata_q;
    logic          drive_q;

    logic          elig0;
    logic          elig1;
    logic          grant;
    logic          grant_port;

    // Arbitration. A port acked this cycle is masked so a requester that is
    // just dropping req cannot be granted a second, spurious access.
    always_comb begin
        elig0      = p0_req & ~p0_ack;
        elig1      = p1_req & ~p1_ack;
        grant      = 1'b0;
        grant_port = 1'b0;
        if (state == IDLE) begin
            if (elig0 && elig1) begin
                grant      = 1'b1;
                grant_port = ~last_grant;
            end else if (elig0) begin
                grant      = 1'b1;
                grant_port = 1'b0;
            end else if (elig1) begin
                grant      = 1'b1;
                grant_port = 1'b1;
            end
        end
    end

    // Next-state logic. Writes take three bus cycles so the strobe sits
    // between a setup and a hold cycle with address and data stable.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (grant_port ? p1_we : p0_we) begin
                        next_state = WSETUP;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = IDLE;
            WSETUP:  next_state = WSTROBE;
            WSTROBE: next_state = WHOLD;
            WHOLD:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and datapath. Strobes are decoded from next_state so
    // they are flop outputs aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            ram_addr   <= '0;
            wdata_q    <= '0;
            drive_q    <= 1'b0;
            ram_read   <= 1'b0;
            ram_write  <= 1'b0;
            busy       <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;

            if (grant) begin
                last_grant <= grant_port;
                ram_addr   <= grant_port ? p1_addr : p0_addr;
                wdata_q    <= grant_port ? p1_wdata : p0_wdata;
            end

            if (state == READ) begin
                if (last_grant) begin
                    p1_rdata <= ram_data;
                end else begin
                    p0_rdata <= ram_data;
                end
            end

            if (state == READ || state == WHOLD) begin
                if (last_grant) begin
                    p1_ack <= 1'b1;
                end else begin
                    p0_ack <= 1'b1;
                end
            end

            ram_read  <= (next_state == READ);
            ram_write <= (next_state == WSTROBE);
            drive_q   <= (next_state == WSETUP) || (next_state == WSTROBE) ||
                         (next_state == WHOLD);
            busy      <= (next_state != IDLE);
        end
    end

    // drive_q and ram_read come from mutually exclusive states, so the bus is
    // never driven while the RAM may be driving it.
    assign ram_data = drive_q ? wdata_q : {DW{1'bz}};

endmodule
